// File: rtl/tx_sched_pkg.sv
// Shared types and default sizing for the transmit pulse scheduler.
// Holds the FSM state encoding and the acknowledge counter width.
package tx_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_SEL_W   = 2;
    localparam int DEF_ACK_TMO = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tx_pulse_scheduler_rr_pick.sv
// Combinational round-robin picker: first set pending bit searching upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_pick
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SEL_W   = DEF_SEL_W
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [SEL_W-1:0]   last_grant,
    output logic [SEL_W-1:0]   winner,
    output logic               valid
);

    logic [SEL_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the channel gi+1 positions after the last grant.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = SEL_W'((int'(last_grant) + gi + 1) % NUM_REQ);
        assign cand_hit[gi] = pending[cand_idx[gi]];
    end

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_pulse_scheduler.sv
// Latches one-cycle channel requests and serialises them round-robin onto a
// single transmitter using a start/busy handshake with acknowledge timeout.
module tx_pulse_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int ACK_TMO = DEF_ACK_TMO
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_ped,
    input  logic               tx_busy,
    input  logic               ovr_clr,
    output logic               tx_start,
    output logic [SEL_W-1:0]   tx_sel,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] overrun,
    output logic               ack_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   tx_sel_reg, tx_sel_next;
    logic [SEL_W-1:0]   last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ack_err_reg, ack_err_next;
    logic [NUM_REQ-1:0] pending_reg, pending_next;
    logic [NUM_REQ-1:0] overrun_reg, overrun_next;
    logic [NUM_REQ-1:0] clr_vec;
    logic [NUM_REQ-1:0] ovr_set;
    logic [SEL_W-1:0]   pick_winner;
    logic               pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .pending    (pending_reg),
        .last_grant (last_grant_reg),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            tx_sel_reg     <= '0;
            last_grant_reg <= SEL_W'(NUM_REQ - 1);
            cnt_reg        <= '0;
            ack_err_reg    <= 1'b0;
            pending_reg    <= '0;
            overrun_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            tx_sel_reg     <= tx_sel_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            ack_err_reg    <= ack_err_next;
            pending_reg    <= pending_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        tx_sel_next     = tx_sel_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        ack_err_next    = 1'b0;
        clr_vec         = '0;

        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next      = ST_START;
                    tx_sel_next     = pick_winner;
                    last_grant_next = pick_winner;
                end
            end
            ST_START: begin
                clr_vec[tx_sel_reg] = 1'b1;
                cnt_next            = '0;
                state_next          = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else begin
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                    // A timed-out request is dropped; its pending bit is already gone.
                    if (int'(cnt_next) >= ACK_TMO) begin
                        ack_err_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // New requests override the grant clear on the same edge.
        ovr_set      = req_ped & pending_reg & ~clr_vec;
        pending_next = (pending_reg & ~clr_vec) | req_ped;
        overrun_next = (overrun_reg & {NUM_REQ{~ovr_clr}}) | ovr_set;
    end

    assign tx_start = (state_reg == ST_START);
    assign tx_sel   = tx_sel_reg;
    assign pending  = pending_reg;
    assign overrun  = overrun_reg;
    assign ack_err  = ack_err_reg;

endmodule

// File: tb/tb_tx_pulse_scheduler.sv
// Directed bench with a grant scoreboard: stimulus pushes expected channels,
// a monitor pops one per tx_start and checks tx_sel.
module tb_tx_pulse_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req_ped = '0;
    logic       tx_busy = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       tx_start;
    logic [1:0] tx_sel;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       ack_err;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] exp_q[$];

    int         resp_cnt = 0;
    bit         ack_en = 1'b1;
    bit         resp_abort = 1'b0;

    tx_pulse_scheduler #(
        .NUM_REQ (4),
        .SEL_W   (2),
        .ACK_TMO (15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_ped  (req_ped),
        .tx_busy  (tx_busy),
        .ovr_clr  (ovr_clr),
        .tx_start (tx_start),
        .tx_sel   (tx_sel),
        .pending  (pending),
        .overrun  (overrun),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises 3 cycles after tx_start and lasts 4 cycles.
    always @(negedge clk) begin
        if (resp_abort) begin
            resp_cnt = 0;
            tx_busy  = 1'b0;
        end else if (resp_cnt != 0) begin
            resp_cnt = resp_cnt - 1;
            tx_busy  = (resp_cnt >= 1 && resp_cnt <= 4);
        end else if (tx_start && ack_en && reset) begin
            resp_cnt = 7;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [1:0] e;
        if (reset && tx_start) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_tx_start got sel=%0d required none", tx_sel);
            end else begin
                e = exp_q.pop_front();
                if (tx_sel !== e) begin
                    tests_failed++;
                    $display("FAIL grant_sel got=%0d required=%0d", tx_sel, e);
                end else begin
                    $display("[TB] grant sel=%0d at %0t", tx_sel, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] v);
        req_ped = v;
        @(negedge clk);
        req_ped = '0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy || resp_cnt != 0 || pending != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 300) begin
            tests_failed++;
            $display("FAIL %s_drain got=timeout queue=%0d required=idle", name, exp_q.size());
        end
        cyc(3);
    endtask

    initial begin
        // Reset state
        cyc(2);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_sel", 32'(tx_sel), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_ack_err", 32'(ack_err), 0);
        reset = 1'b1;
        cyc(2);

        // Fairness: all four at once, first grant after reset is channel 0
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        pulse(4'b1111);
        check("fair_pending", 32'(pending), 32'hF);
        drain("fair");
        exp_q.push_back(2'd0);
        pulse(4'b0001);
        drain("fair_next");

        // Single request latency
        exp_q.push_back(2'd1);
        pulse(4'b0010);
        check("single_pending_set", 32'(pending), 32'h2);
        check("single_no_early_start", 32'(tx_start), 0);
        cyc(1);
        check("single_start_c2", 32'(tx_start), 1);
        cyc(1);
        check("single_start_one_cycle", 32'(tx_start), 0);
        check("single_pending_clr", 32'(pending), 0);
        drain("single");

        // Overrun on channel 2 while it waits behind channel 0
        exp_q.push_back(2'd0); exp_q.push_back(2'd2);
        pulse(4'b0001);
        cyc(2);
        pulse(4'b0100);
        check("ovr_pending", 32'(pending), 32'h4);
        check("ovr_none_yet", 32'(overrun), 0);
        cyc(1);
        pulse(4'b0100);
        check("ovr_set", 32'(overrun), 32'h4);
        pulse(4'b0100);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);
        check("ovr_still_pending", 32'(pending), 32'h4);
        drain("ovr");

        // Set/clear collision on channel 1
        exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        pulse(4'b0010);
        cyc(1);
        check("coll_start", 32'(tx_start), 1);
        pulse(4'b0010);
        check("coll_pending_kept", 32'(pending), 32'h2);
        check("coll_no_overrun", 32'(overrun), 0);
        drain("coll");

        // Acknowledge timeout on channel 3
        ack_en = 1'b0;
        exp_q.push_back(2'd3);
        pulse(4'b1000);
        cyc(2);
        check("tmo_pending_clr", 32'(pending), 0);
        cyc(14);
        check("tmo_no_err_early", 32'(ack_err), 0);
        cyc(1);
        check("tmo_ack_err", 32'(ack_err), 1);
        ack_en = 1'b1;
        exp_q.push_back(2'd0);
        pulse(4'b0001);
        check("tmo_err_one_cycle", 32'(ack_err), 0);
        cyc(1);
        check("tmo_idle_regrant", 32'(tx_start), 1);
        drain("tmo");

        // Asynchronous reset mid WAIT_DONE with 1010 pending
        exp_q.push_back(2'd2);
        pulse(4'b0100);
        cyc(3);
        pulse(4'b1010);
        cyc(1);
        check("arst_pre_pending", 32'(pending), 32'hA);
        check("arst_pre_sel", 32'(tx_sel), 2);
        check("arst_pre_busy", 32'(tx_busy), 1);
        #2;
        reset = 1'b0;
        resp_abort = 1'b1;
        #1;
        check("arst_tx_start", 32'(tx_start), 0);
        check("arst_tx_sel", 32'(tx_sel), 0);
        check("arst_pending", 32'(pending), 0);
        check("arst_overrun", 32'(overrun), 0);
        check("arst_ack_err", 32'(ack_err), 0);
        cyc(3);
        reset = 1'b1;
        resp_abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("arst_quiet", 32'(tx_start), 0);
        end
        check("arst_quiet_pending", 32'(pending), 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
